// File: rtl/breath_pwm_pkg.sv
// Shared definitions for the breathing RGB PWM driver: colour codes,
// ramp states, RGB payload and the colour-to-base-level lookup.
package breath_pwm_pkg;

  localparam int unsigned COLOR_W = 3;
  localparam int unsigned BASE_W  = 8;

  typedef enum logic [COLOR_W-1:0] {
    COLOR_RED    = 3'd0,
    COLOR_ORANGE = 3'd1,
    COLOR_YELLOW = 3'd2,
    COLOR_GREEN  = 3'd3,
    COLOR_BLUE   = 3'd4,
    COLOR_PURPLE = 3'd5
  } color_e;

  typedef enum logic {
    RISE = 1'b0,
    FALL = 1'b1
  } ramp_state_e;

  typedef struct packed {
    logic [BASE_W-1:0] r;
    logic [BASE_W-1:0] g;
    logic [BASE_W-1:0] b;
  } rgb_t;

  localparam logic [BASE_W-1:0] LVL_OFF  = 8'd0;
  localparam logic [BASE_W-1:0] LVL_HALF = 8'd128;
  localparam logic [BASE_W-1:0] LVL_FULL = 8'd255;

  // Base RGB levels per colour code; unused codes map to black.
  function automatic rgb_t color_base(input logic [COLOR_W-1:0] code);
    rgb_t base;
    base = '{r: LVL_OFF, g: LVL_OFF, b: LVL_OFF};
    case (code)
      COLOR_RED:    base = '{r: LVL_FULL, g: LVL_OFF,  b: LVL_OFF};
      COLOR_ORANGE: base = '{r: LVL_FULL, g: LVL_HALF, b: LVL_OFF};
      COLOR_YELLOW: base = '{r: LVL_FULL, g: LVL_FULL, b: LVL_OFF};
      COLOR_GREEN:  base = '{r: LVL_OFF,  g: LVL_FULL, b: LVL_OFF};
      COLOR_BLUE:   base = '{r: LVL_OFF,  g: LVL_OFF,  b: LVL_FULL};
      COLOR_PURPLE: base = '{r: LVL_HALF, g: LVL_OFF,  b: LVL_FULL};
      default:      base = '{r: LVL_OFF,  g: LVL_OFF,  b: LVL_OFF};
    endcase
    return base;
  endfunction

endpackage

// File: rtl/breath_ramp.sv
// Brightness ramp: prescaler producing a step tick every STEP_CYCLES clocks
// and a RISE/FALL FSM sweeping bright 0..MAX..0.
// Ports: clk_i, rst_n_i (async active-low), bright_o (current level),
//        breath_done_o (one-clock pulse as bright returns to 0).
module breath_ramp
  import breath_pwm_pkg::*;
#(
  parameter int unsigned PWM_W       = 8,
  parameter int unsigned STEP_CYCLES = 19531
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  output logic [PWM_W-1:0] bright_o,
  output logic             breath_done_o
);

  localparam int unsigned      PRE_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_CYCLES - 1);
  localparam logic [PWM_W-1:0] MAX      = '1;
  localparam logic [PWM_W-1:0] ONE      = PWM_W'(1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PWM_W-1:0] bright_q, bright_d;
  ramp_state_e      state_q, state_d;
  logic             done_q, done_d;
  logic             step_tick;

  // Prescaler wraps on the last count, which is also the step tick.
  assign step_tick = (pre_q == PRE_LAST);
  assign pre_d     = step_tick ? '0 : pre_q + 1'b1;

  // Ramp FSM next state; only moves on a step tick.
  always_comb begin
    state_d  = state_q;
    bright_d = bright_q;
    done_d   = 1'b0;
    if (step_tick) begin
      case (state_q)
        RISE: begin
          if (bright_q == MAX) begin
            bright_d = MAX - 1'b1;
            state_d  = FALL;
          end else begin
            bright_d = bright_q + 1'b1;
          end
        end
        FALL: begin
          if (bright_q == ONE) begin
            bright_d = '0;
            state_d  = RISE;
            done_d   = 1'b1;
          end else begin
            bright_d = bright_q - 1'b1;
          end
        end
        default: state_d = RISE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pre_q    <= '0;
      bright_q <= '0;
      state_q  <= RISE;
      done_q   <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      bright_q <= bright_d;
      state_q  <= state_d;
      done_q   <= done_d;
    end
  end

  assign bright_o      = bright_q;
  assign breath_done_o = done_q;

endmodule

// File: rtl/breath_pwm.sv
// Breathing RGB LED driver: latches the sequencer colour at each breath
// minimum, scales its base levels by the ramp brightness and drives three
// registered PWM pins.
// Ports: clk_i, rst_n_i (async active-low), color_i (colour code),
//        led_r_o/led_g_o/led_b_o (PWM, active high),
//        breath_done_o (one-clock pulse at each breath minimum).
module breath_pwm
  import breath_pwm_pkg::*;
#(
  parameter int unsigned PWM_W       = 8,
  parameter int unsigned STEP_CYCLES = 19531
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [COLOR_W-1:0] color_i,
  output logic               led_r_o,
  output logic               led_g_o,
  output logic               led_b_o,
  output logic               breath_done_o
);

  localparam int unsigned      PROD_W = 2 * PWM_W;
  localparam logic [PWM_W-1:0] MAX    = '1;

  logic [PWM_W-1:0]   bright;
  logic               ramp_done;
  logic [COLOR_W-1:0] color_q, color_d;
  rgb_t               base;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0]   duty_r_q, duty_g_q, duty_b_q;
  logic [PWM_W-1:0]   duty_r_d, duty_g_d, duty_b_d;
  logic               led_r_q, led_g_q, led_b_q;
  logic               period_end;

  breath_ramp #(
    .PWM_W       (PWM_W),
    .STEP_CYCLES (STEP_CYCLES)
  ) u_ramp (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .bright_o      (bright),
    .breath_done_o (ramp_done)
  );

  // Colour only changes at a breath minimum, when brightness is zero.
  assign color_d = ramp_done ? color_i : color_q;

  // Duty = upper half of base*bright, truncated.
  always_comb begin
    base     = color_base(color_q);
    duty_r_d = PWM_W'((PROD_W'(base.r) * PROD_W'(bright)) >> PWM_W);
    duty_g_d = PWM_W'((PROD_W'(base.g) * PROD_W'(bright)) >> PWM_W);
    duty_b_d = PWM_W'((PROD_W'(base.b) * PROD_W'(bright)) >> PWM_W);
  end

  assign period_end = (pwm_cnt_q == MAX);
  assign pwm_cnt_d  = period_end ? '0 : pwm_cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      color_q   <= COLOR_RED;
      pwm_cnt_q <= '0;
      duty_r_q  <= '0;
      duty_g_q  <= '0;
      duty_b_q  <= '0;
      led_r_q   <= 1'b0;
      led_g_q   <= 1'b0;
      led_b_q   <= 1'b0;
    end else begin
      color_q   <= color_d;
      pwm_cnt_q <= pwm_cnt_d;
      // Duties reload only at the period boundary so a period never glitches.
      if (period_end) begin
        duty_r_q <= duty_r_d;
        duty_g_q <= duty_g_d;
        duty_b_q <= duty_b_d;
      end
      led_r_q <= (pwm_cnt_q < duty_r_q);
      led_g_q <= (pwm_cnt_q < duty_g_q);
      led_b_q <= (pwm_cnt_q < duty_b_q);
    end
  end

  assign led_r_o       = led_r_q;
  assign led_g_o       = led_g_q;
  assign led_b_o       = led_b_q;
  assign breath_done_o = ramp_done;

endmodule

// File: tb/tb_breath_pwm.sv
// Directed bench for breath_pwm with STEP_CYCLES=4. cyc counts rising edges
// since reset release; all sampling happens on the falling edge, so a sample
// taken when cyc==k shows the state right after edge k.
module tb_breath_pwm;
  import breath_pwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] color = 3'd0;
  logic       led_r, led_g, led_b, done;

  int checks = 0;
  int passed = 0;
  int cyc;
  int nr, ng, nb, nd;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  breath_pwm #(
    .PWM_W       (8),
    .STEP_CYCLES (4)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .color_i       (color),
    .led_r_o       (led_r),
    .led_g_o       (led_g),
    .led_b_o       (led_b),
    .breath_done_o (done)
  );

  // Advance one falling edge at a time up to cyc==hi, accumulating high counts.
  task automatic step_count(input int hi);
    int guard = 0;
    while (cyc < hi && guard < 20000) begin
      @(negedge clk);
      guard++;
      nr += int'(led_r);
      ng += int'(led_g);
      nb += int'(led_b);
      nd += int'(done);
    end
    if (cyc != hi) begin
      checks++;
      $display("FAIL step_count: reached cyc %0d, wanted %0d", cyc, hi);
    end
  endtask

  task automatic clear_counts();
    nr = 0; ng = 0; nb = 0; nd = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
  endtask

  task automatic test_reset();
    color = COLOR_RED;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({led_r, led_g, led_b, done} !== 4'b0) $display("FAIL reset_outputs: got %b want 0000", {led_r, led_g, led_b, done}); else passed++;
    checks++; if (dut.bright !== 8'd0) $display("FAIL reset_bright: got %0d want 0", dut.bright); else passed++;
    rst_n = 1'b1;
    clear_counts();
    // After edge 1026 the peak duty 254 has led_r high (pwm_cnt 1 < 254).
    step_count(1026);
    checks++; if (led_r !== 1'b1) $display("FAIL pre_async_led_r: got %b want 1", led_r); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({led_r, led_g, led_b, done} !== 4'b0) $display("FAIL async_reset_outputs: got %b want 0000", {led_r, led_g, led_b, done}); else passed++;
    checks++; if (dut.bright !== 8'd0) $display("FAIL async_reset_bright: got %0d want 0", dut.bright); else passed++;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
  endtask

  // Red breath with ORANGE pending; ORANGE takes effect in the second breath.
  task automatic test_red_breath();
    color = COLOR_ORANGE;
    step_count(4);
    checks++; if (dut.bright !== 8'd1) $display("FAIL first_step: got %0d want 1", dut.bright); else passed++;
    step_count(1020);
    checks++; if (dut.bright !== 8'd255) $display("FAIL peak_bright: got %0d want 255", dut.bright); else passed++;
    step_count(1024);
    checks++; if (dut.bright !== 8'd254 || dut.u_ramp.state_q !== FALL) $display("FAIL turn_to_fall: got bright %0d state %0d want 254/FALL", dut.bright, dut.u_ramp.state_q); else passed++;
    // Duty captured at edge 1024 from bright 255: red (255*255)>>8 = 254.
    nr = 0; ng = 0; nb = 0;
    step_count(1280);
    checks++; if (nr !== 254) $display("FAIL red_peak_duty: got %0d want 254", nr); else passed++;
    checks++; if (ng !== 0 || nb !== 0) $display("FAIL red_peak_gb: got g=%0d b=%0d want 0/0", ng, nb); else passed++;
    step_count(2039);
    checks++; if (nd !== 0) $display("FAIL early_done: got %0d pulses want 0", nd); else passed++;
    checks++; if (ng !== 0) $display("FAIL pending_orange_visible: got g=%0d want 0", ng); else passed++;
    step_count(2040);
    checks++; if (done !== 1'b1 || dut.bright !== 8'd0 || dut.u_ramp.state_q !== RISE) $display("FAIL done_pulse: got done %b bright %0d state %0d want 1/0/RISE", done, dut.bright, dut.u_ramp.state_q); else passed++;
    step_count(2041);
    checks++; if (done !== 1'b0) $display("FAIL done_width: got %b want 0", done); else passed++;
    checks++; if (dut.color_q !== 3'(COLOR_ORANGE)) $display("FAIL latch_orange: got %0d want 1", dut.color_q); else passed++;
    step_count(3060);
    checks++; if (dut.duty_g_d !== 8'd127 || dut.duty_r_d !== 8'd254) $display("FAIL orange_peak_duty: got r=%0d g=%0d want 254/127", dut.duty_r_d, dut.duty_g_d); else passed++;
    // Edge 3072 captures bright 253: red 252, green (128*253)>>8 = 126.
    step_count(3072);
    nr = 0; ng = 0; nb = 0;
    step_count(3328);
    checks++; if (nr !== 252 || ng !== 126 || nb !== 0) $display("FAIL orange_period: got r=%0d g=%0d b=%0d want 252/126/0", nr, ng, nb); else passed++;
  endtask

  // RED -> BLUE mid-breath, then code 6 (black) for a later breath.
  task automatic test_color_switch();
    color = COLOR_RED;
    do_reset();
    step_count(400);
    checks++; if (dut.bright !== 8'd100) $display("FAIL switch_point: got %0d want 100", dut.bright); else passed++;
    color = COLOR_BLUE;
    nr = 0; ng = 0; nb = 0;
    step_count(2039);
    checks++; if (nb !== 0 || nr == 0) $display("FAIL stay_red: got r=%0d b=%0d want r>0 b=0", nr, nb); else passed++;
    step_count(2040);
    checks++; if (done !== 1'b1 || nd !== 1) $display("FAIL switch_done: got done %b count %0d want 1/1", done, nd); else passed++;
    clear_counts();
    step_count(2100);
    color = 3'd6;
    step_count(4079);
    checks++; if (nr !== 0 || ng !== 0 || nb == 0) $display("FAIL blue_breath: got r=%0d g=%0d b=%0d want 0/0/>0", nr, ng, nb); else passed++;
    step_count(4080);
    checks++; if (done !== 1'b1) $display("FAIL blue_done: got %b want 1", done); else passed++;
  endtask

  task automatic test_invalid_color();
    clear_counts();
    step_count(6119);
    checks++; if (nr !== 0 || ng !== 0 || nb !== 0) $display("FAIL black_breath: got r=%0d g=%0d b=%0d want 0/0/0", nr, ng, nb); else passed++;
    checks++; if (nd !== 0) $display("FAIL black_early_done: got %0d want 0", nd); else passed++;
    step_count(6120);
    checks++; if (done !== 1'b1) $display("FAIL black_done: got %b want 1", done); else passed++;
  endtask

  task automatic test_reset_in_fall();
    color = COLOR_RED;
    do_reset();
    step_count(1800);
    color = COLOR_GREEN;
    step_count(1840);
    checks++; if (dut.bright !== 8'd50 || dut.u_ramp.state_q !== FALL) $display("FAIL fall_50: got bright %0d state %0d want 50/FALL", dut.bright, dut.u_ramp.state_q); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (dut.bright !== 8'd0 || dut.u_ramp.state_q !== RISE) $display("FAIL fall_reset: got bright %0d state %0d want 0/RISE", dut.bright, dut.u_ramp.state_q); else passed++;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    checks++; if (dut.color_q !== 3'(COLOR_RED)) $display("FAIL reset_color: got %0d want 0", dut.color_q); else passed++;
    step_count(3);
    checks++; if (dut.bright !== 8'd0) $display("FAIL restart_0: got %0d want 0", dut.bright); else passed++;
    for (int s = 1; s <= 3; s++) begin
      step_count(4 * s);
      checks++; if (dut.bright !== 8'(s)) $display("FAIL restart_step%0d: got %0d want %0d", s, dut.bright, s); else passed++;
    end
    step_count(2039);
    checks++; if (nd !== 0 || ng !== 0 || nr == 0) $display("FAIL restart_breath: got done=%0d g=%0d r=%0d want 0/0/>0", nd, ng, nr); else passed++;
    step_count(2040);
    checks++; if (done !== 1'b1) $display("FAIL restart_done: got %b want 1", done); else passed++;
  endtask

  initial begin
    test_reset();
    test_red_breath();
    test_color_switch();
    test_invalid_color();
    test_reset_in_fall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
